// File: rtl/aibndaux_ctrl_pkg.sv
// Shared state encoding and default timing constants for the aux connect/POR controller.
package aibndaux_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DBNC = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } ctrl_state_e;

  localparam int unsigned DBNC_CYC_DEF     = 8;
  localparam int unsigned POR_HOLD_CYC_DEF = 64;

endpackage

// File: rtl/aibndaux_sync2.sv
// Two-flop synchronizer for the partner connect indication; both stages reset to 0.
module aibndaux_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/aibndaux_crdet_por_ctrl.sv
// Partner-die connect debounce and POR sequencing on the aux oscillator clock.
// Define AIBNDAUX_CRDET_SYNC_EN to synchronize crete_detect through aibndaux_sync2.
//   state | meaning
//   IDLE  | disabled or no partner; dn_por held
//   DBNC  | qualifying a stable connect level
//   HOLD  | partner held in POR for POR_HOLD_CYC cycles
//   RUN   | link up, POR released, watching for disconnect
module aibndaux_crdet_por_ctrl
  import aibndaux_ctrl_pkg::*;
#(
  parameter int unsigned DBNC_CYC     = DBNC_CYC_DEF,
  parameter int unsigned POR_HOLD_CYC = POR_HOLD_CYC_DEF
) (
  input  logic       osc_clk,
  input  logic       osc_rst,
  input  logic       ctrl_en,
  input  logic       crete_detect,
  input  logic       sw_por_req,
  output logic       dn_por,
  output logic       por_done,
  output logic       disc_evt,
  output logic [1:0] ctrl_state
);

  localparam int DW = $clog2(DBNC_CYC + 1);
  localparam int HW = $clog2(POR_HOLD_CYC + 1);
  localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(POR_HOLD_CYC - 1);

  logic det;

`ifdef AIBNDAUX_CRDET_SYNC_EN
  aibndaux_sync2 u_sync2 (
    .clk (osc_clk),
    .rst (osc_rst),
    .d   (crete_detect),
    .q   (det)
  );
`else
  assign det = crete_detect;
`endif

  ctrl_state_e   state_q, state_nxt;
  logic [DW-1:0] dbnc_q, dbnc_nxt;
  logic [DW-1:0] low_q, low_nxt;
  logic [HW-1:0] hold_q, hold_nxt;
  logic          disc_nxt;
  logic          disc_qual;

  // Low-level run length shared by HOLD and RUN; any high sample restarts it.
  assign disc_qual = !det && (low_q == DBNC_LAST);

  always_comb begin
    state_nxt = state_q;
    dbnc_nxt  = dbnc_q;
    low_nxt   = low_q;
    hold_nxt  = hold_q;
    disc_nxt  = 1'b0;

    case (state_q)
      IDLE: begin
        dbnc_nxt = '0;
        low_nxt  = '0;
        hold_nxt = '0;
        if (det) state_nxt = DBNC;
      end
      DBNC: begin
        if (!det) begin
          state_nxt = IDLE;
          dbnc_nxt  = '0;
        end else if (dbnc_q == DBNC_LAST) begin
          state_nxt = HOLD;
          dbnc_nxt  = '0;
          low_nxt   = '0;
          hold_nxt  = '0;
        end else begin
          dbnc_nxt = (dbnc_q == '1) ? dbnc_q : dbnc_q + 1'b1;
        end
      end
      HOLD: begin
        low_nxt = det ? '0 : ((low_q == '1) ? low_q : low_q + 1'b1);
        if (disc_qual) begin
          state_nxt = IDLE;
          low_nxt   = '0;
          hold_nxt  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_nxt = RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        end
      end
      RUN: begin
        low_nxt = det ? '0 : ((low_q == '1) ? low_q : low_q + 1'b1);
        // A qualified disconnect outranks a software re-POR in the same cycle.
        if (disc_qual) begin
          state_nxt = IDLE;
          disc_nxt  = 1'b1;
          low_nxt   = '0;
        end else if (sw_por_req) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (!ctrl_en) begin
      state_nxt = IDLE;
      dbnc_nxt  = '0;
      low_nxt   = '0;
      hold_nxt  = '0;
      disc_nxt  = 1'b0;
    end
  end

  always_ff @(posedge osc_clk) begin
    if (osc_rst) begin
      state_q  <= IDLE;
      dbnc_q   <= '0;
      low_q    <= '0;
      hold_q   <= '0;
      dn_por   <= 1'b1;
      por_done <= 1'b0;
      disc_evt <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      dbnc_q   <= dbnc_nxt;
      low_q    <= low_nxt;
      hold_q   <= hold_nxt;
      dn_por   <= (state_nxt != RUN);
      por_done <= (state_nxt == RUN);
      disc_evt <= disc_nxt;
    end
  end

  assign ctrl_state = state_q;

endmodule

// File: tb/tb_aibndaux_crdet_por_ctrl.sv
// Directed bench for aibndaux_crdet_por_ctrl at default parameters; tracks synchronizer latency.
module tb_aibndaux_crdet_por_ctrl;

`ifdef AIBNDAUX_CRDET_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic       osc_clk;
  logic       osc_rst;
  logic       ctrl_en;
  logic       crete_detect;
  logic       sw_por_req;
  logic       dn_por;
  logic       por_done;
  logic       disc_evt;
  logic [1:0] ctrl_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  aibndaux_crdet_por_ctrl dut (
    .osc_clk      (osc_clk),
    .osc_rst      (osc_rst),
    .ctrl_en      (ctrl_en),
    .crete_detect (crete_detect),
    .sw_por_req   (sw_por_req),
    .dn_por       (dn_por),
    .por_done     (por_done),
    .disc_evt     (disc_evt),
    .ctrl_state   (ctrl_state)
  );

  initial osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic wait_run(input int budget);
    int n;
    n = 0;
    while (ctrl_state != 2'd3 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_run", {30'd0, ctrl_state}, 32'd3);
  endtask

  function automatic logic [1:0] exp_bringup(input int i);
    if (i <= SL)          return 2'd0;
    else if (i <= SL + 8) return 2'd1;
    else                  return 2'd2;
  endfunction

  initial begin
    osc_rst      = 1'b1;
    ctrl_en      = 1'b0;
    crete_detect = 1'b0;
    sw_por_req   = 1'b0;
    tick();
    tick();
    chk("rst_state", {30'd0, ctrl_state}, 32'd0);
    chk("rst_dnpor", {31'd0, dn_por}, 32'd1);
    chk("rst_done", {31'd0, por_done}, 32'd0);
    chk("rst_disc", {31'd0, disc_evt}, 32'd0);

    // Bring-up: 8 debounce + 64 hold cycles with dn_por asserted.
    osc_rst      = 1'b0;
    ctrl_en      = 1'b1;
    crete_detect = 1'b1;
    for (int i = 1; i <= 72 + SL; i++) begin
      tick();
      chk("up_dnpor", {31'd0, dn_por}, 32'd1);
      chk("up_state", {30'd0, ctrl_state}, {30'd0, exp_bringup(i)});
    end
    tick();
    chk("up_run_state", {30'd0, ctrl_state}, 32'd3);
    chk("up_run_dnpor", {31'd0, dn_por}, 32'd0);
    chk("up_run_done", {31'd0, por_done}, 32'd1);
    chk("up_run_disc", {31'd0, disc_evt}, 32'd0);

    // 7-cycle low glitch in RUN is ignored.
    crete_detect = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("glitch_state", {30'd0, ctrl_state}, 32'd3);
      chk("glitch_disc", {31'd0, disc_evt}, 32'd0);
    end
    crete_detect = 1'b1;
    for (int i = 0; i < SL + 3; i++) begin
      tick();
      chk("glitch_rec_state", {30'd0, ctrl_state}, 32'd3);
      chk("glitch_rec_disc", {31'd0, disc_evt}, 32'd0);
    end

    // 8-cycle low qualifies a disconnect.
    crete_detect = 1'b0;
    for (int i = 0; i < 7 + SL; i++) begin
      tick();
      chk("disc_pre_state", {30'd0, ctrl_state}, 32'd3);
      chk("disc_pre_evt", {31'd0, disc_evt}, 32'd0);
    end
    tick();
    chk("disc_state", {30'd0, ctrl_state}, 32'd0);
    chk("disc_evt", {31'd0, disc_evt}, 32'd1);
    chk("disc_dnpor", {31'd0, dn_por}, 32'd1);
    chk("disc_done", {31'd0, por_done}, 32'd0);
    tick();
    chk("disc_evt_1cyc", {31'd0, disc_evt}, 32'd0);
    chk("disc_idle", {30'd0, ctrl_state}, 32'd0);

    // Debounce broken at count 5, then a full restart.
    crete_detect = 1'b1;
    repeat (1 + SL) tick();
    chk("db_enter", {30'd0, ctrl_state}, 32'd1);
    repeat (5) tick();
    chk("db_cnt5", {30'd0, ctrl_state}, 32'd1);
    crete_detect = 1'b0;
    tick();
    crete_detect = 1'b1;
    repeat (SL) tick();
    chk("db_abort_state", {30'd0, ctrl_state}, 32'd0);
    chk("db_abort_dnpor", {31'd0, dn_por}, 32'd1);
    tick();
    chk("db_reenter", {30'd0, ctrl_state}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("db_restart", {30'd0, ctrl_state}, 32'd1);
    end
    tick();
    chk("db_to_hold", {30'd0, ctrl_state}, 32'd2);
    for (int i = 0; i < 63; i++) begin
      tick();
      chk("hold_state", {30'd0, ctrl_state}, 32'd2);
    end
    tick();
    chk("hold_to_run", {30'd0, ctrl_state}, 32'd3);

    // Software re-POR: dn_por high for exactly 64 cycles.
    sw_por_req = 1'b1;
    tick();
    sw_por_req = 1'b0;
    chk("sw_state", {30'd0, ctrl_state}, 32'd2);
    chk("sw_dnpor", {31'd0, dn_por}, 32'd1);
    for (int i = 0; i < 63; i++) begin
      tick();
      chk("sw_dnpor_hold", {31'd0, dn_por}, 32'd1);
    end
    tick();
    chk("sw_rel_dnpor", {31'd0, dn_por}, 32'd0);
    chk("sw_rel_state", {30'd0, ctrl_state}, 32'd3);
    chk("sw_rel_done", {31'd0, por_done}, 32'd1);

    // sw_por_req coinciding with a qualified disconnect loses.
    crete_detect = 1'b0;
    for (int i = 0; i < 7 + SL; i++) begin
      tick();
      chk("race_pre_state", {30'd0, ctrl_state}, 32'd3);
    end
    sw_por_req = 1'b1;
    tick();
    sw_por_req = 1'b0;
    chk("race_state", {30'd0, ctrl_state}, 32'd0);
    chk("race_disc", {31'd0, disc_evt}, 32'd1);
    chk("race_dnpor", {31'd0, dn_por}, 32'd1);
    sw_por_req = 1'b1;
    tick();
    sw_por_req = 1'b0;
    chk("sw_idle_ignored", {30'd0, ctrl_state}, 32'd0);

    // Reset asserted in HOLD.
    crete_detect = 1'b1;
    repeat (1 + SL) tick();
    chk("r_dbnc", {30'd0, ctrl_state}, 32'd1);
    repeat (8) tick();
    chk("r_hold", {30'd0, ctrl_state}, 32'd2);
    osc_rst = 1'b1;
    tick();
    osc_rst = 1'b0;
    chk("r_mid_state", {30'd0, ctrl_state}, 32'd0);
    chk("r_mid_dnpor", {31'd0, dn_por}, 32'd1);
    chk("r_mid_done", {31'd0, por_done}, 32'd0);
    chk("r_mid_disc", {31'd0, disc_evt}, 32'd0);
    wait_run(200);

    // ctrl_en drop outranks a disconnect qualifying on the same edge.
    crete_detect = 1'b0;
    for (int i = 0; i < 7 + SL; i++) begin
      tick();
      chk("en_pre_state", {30'd0, ctrl_state}, 32'd3);
    end
    ctrl_en = 1'b0;
    tick();
    chk("en_state", {30'd0, ctrl_state}, 32'd0);
    chk("en_dnpor", {31'd0, dn_por}, 32'd1);
    chk("en_done", {31'd0, por_done}, 32'd0);
    chk("en_disc", {31'd0, disc_evt}, 32'd0);
    tick();
    chk("en_disc_after", {31'd0, disc_evt}, 32'd0);
    crete_detect = 1'b1;
    repeat (12) tick();
    chk("en_low_idle", {30'd0, ctrl_state}, 32'd0);
    chk("en_low_dnpor", {31'd0, dn_por}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
